// File: rtl/milano_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package milano_fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, addr} holding register used while ID is stalled.
module fetch_skid_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      addr_q  <= addr_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, instr-RAM handshake, skid buffer, redirect flush.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl
  import milano_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [31:0]       instr_rdata_i,
  input  logic              id_stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              if_valid_o,
  output logic [31:0]       if_instr_o,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic              ifid_flush_o,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_redir_cnt_o
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redir_pc;
  logic              pass_sel;
  logic              hold_sel;
  logic              buf_load;
  logic              buf_clear;
  logic              buf_valid;
  logic [31:0]       buf_instr;
  logic [ADDR_W-1:0] buf_addr;

  assign pc_inc   = pc_q + ADDR_W'(PC_STEP);
  assign redir_pc = redirect_addr_i & ~ADDR_W'(3);
  assign pass_sel = (state_q == WAIT) && instr_rvalid_i;
  assign hold_sel = (state_q == HOLD);

  assign buf_load  = pass_sel && id_stall_i && !redirect_i;
  assign buf_clear = redirect_i || (hold_sel && !id_stall_i);

  fetch_skid_buf #(
    .ADDR_W (ADDR_W)
  ) u_skid_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (instr_rdata_i),
    .addr_i  (pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .addr_o  (buf_addr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDR;
    end else if (redirect_i) begin
      pc_q <= redir_pc;
      // A granted-but-unreturned request must have its data discarded.
      if (((state_q == REQ) && instr_gnt_i) || ((state_q == WAIT) && !instr_rvalid_i)) begin
        state_q <= DROP;
      end else begin
        state_q <= REQ;
      end
    end else begin
      case (state_q)
        BOOT: state_q <= REQ;
        REQ:  if (instr_gnt_i) state_q <= WAIT;
        WAIT: begin
          if (instr_rvalid_i) begin
            if (id_stall_i) begin
              state_q <= HOLD;
            end else begin
              pc_q    <= pc_inc;
              state_q <= REQ;
            end
          end
        end
        HOLD: begin
          if (!id_stall_i) begin
            pc_q    <= pc_inc;
            state_q <= REQ;
          end
        end
        DROP: if (instr_rvalid_i) state_q <= REQ;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign instr_req_o  = (state_q == REQ);
  assign instr_addr_o = pc_q;
  assign ifid_flush_o = redirect_i;

  always_comb begin
    if_valid_o = 1'b0;
    if_instr_o = '0;
    if_addr_o  = '0;
    if (hold_sel) begin
      if_instr_o = buf_instr;
      if_addr_o  = buf_addr;
      if_valid_o = buf_valid && !id_stall_i && !redirect_i;
    end else if (pass_sel) begin
      if_instr_o = instr_rdata_i;
      if_addr_o  = pc_q;
      if_valid_o = !id_stall_i && !redirect_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (hold_sel && id_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_i && (redir_cnt_q != 32'hFFFF_FFFF)) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_redir_cnt_o = redir_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_redir_cnt_o = '0;
`endif

  // Read data may only arrive while a request is outstanding or being discarded.
  rvalid_protocol_a: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> !(state_q inside {REQ, HOLD}));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch stream, stall hold, redirects, wrap, perf counters.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_addr;
  logic        ifid_flush;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redir_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W    (32),
    .BOOT_ADDR (32'h0000_0000)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_req_o      (instr_req),
    .instr_addr_o     (instr_addr),
    .instr_gnt_i      (instr_gnt),
    .instr_rvalid_i   (instr_rvalid),
    .instr_rdata_i    (instr_rdata),
    .id_stall_i       (id_stall),
    .redirect_i       (redirect),
    .redirect_addr_i  (redirect_addr),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_addr_o        (if_addr),
    .ifid_flush_o     (ifid_flush),
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_redir_cnt_o (perf_redir_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_gnt = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0;
    id_stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
    settle();
    total++;
    if ({instr_req, instr_addr, if_valid, ifid_flush} !== {1'b0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_ctl: got %h want %h",
               {instr_req, instr_addr, if_valid, ifid_flush}, 35'h0);
    else passed++;
    total++;
    if ({if_instr, if_addr, perf_stall_cnt, perf_redir_cnt} !== 128'h0)
      $display("FAIL reset_data: got %h want 0",
               {if_instr, if_addr, perf_stall_cnt, perf_redir_cnt});
    else passed++;
    step();
    rst = 1'b0;
    settle();
    total++;
    if (instr_req !== 1'b0) $display("FAIL boot_noreq: got %b want 0", instr_req);
    else passed++;
    step();
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if ({instr_req, instr_addr, if_valid} !== {1'b1, 32'(4 * i), 1'b0})
        $display("FAIL fetch_req%0d: got %h want %h", i, {instr_req, instr_addr, if_valid},
                 {1'b1, 32'(4 * i), 1'b0});
      else passed++;
      instr_gnt = 1'b1;
      step();
      instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h1000_0000 + 32'(i);
      settle();
      total++;
      if ({instr_req, if_valid, if_addr, if_instr} !==
          {1'b0, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i)})
        $display("FAIL fetch_data%0d: got %h want %h", i, {instr_req, if_valid, if_addr, if_instr},
                 {1'b0, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i)});
      else passed++;
      step();
      instr_rvalid = 1'b0;
    end
  endtask

  task automatic test_stall();
    settle();
    total++;
    if ({instr_req, instr_addr} !== {1'b1, 32'hC})
      $display("FAIL stall_req: got %h want %h", {instr_req, instr_addr}, {1'b1, 32'hC});
    else passed++;
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h0050_0093; id_stall = 1'b1;
    settle();
    total++;
    if (if_valid !== 1'b0) $display("FAIL stall_wait_valid: got %b want 0", if_valid);
    else passed++;
    step();
    instr_rvalid = 1'b0; instr_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++;
      if ({if_valid, if_addr, if_instr, instr_req} !== {1'b0, 32'hC, 32'h0050_0093, 1'b0})
        $display("FAIL stall_hold%0d: got %h want %h", k, {if_valid, if_addr, if_instr, instr_req},
                 {1'b0, 32'hC, 32'h0050_0093, 1'b0});
      else passed++;
      step();
    end
    id_stall = 1'b0;
    settle();
    total++;
    if ({if_valid, if_addr, if_instr} !== {1'b1, 32'hC, 32'h0050_0093})
      $display("FAIL stall_release: got %h want %h", {if_valid, if_addr, if_instr},
               {1'b1, 32'hC, 32'h0050_0093});
    else passed++;
    step();
    settle();
    total++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h10})
      $display("FAIL stall_next_req: got %h want %h", {instr_req, instr_addr}, {1'b1, 32'h10});
    else passed++;
  endtask

  task automatic test_redirect_wait();
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; redirect = 1'b1; redirect_addr = 32'h100;
    settle();
    total++;
    if ({ifid_flush, if_valid, instr_req} !== 3'b100)
      $display("FAIL rw_flush: got %b want 100", {ifid_flush, if_valid, instr_req});
    else passed++;
    step();
    redirect = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'hDEAD_BEEF;
    settle();
    total++;
    if ({ifid_flush, if_valid, instr_req} !== 3'b000)
      $display("FAIL rw_drop: got %b want 000", {ifid_flush, if_valid, instr_req});
    else passed++;
    step();
    instr_rvalid = 1'b0;
    settle();
    total++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h100})
      $display("FAIL rw_req: got %h want %h", {instr_req, instr_addr}, {1'b1, 32'h100});
    else passed++;
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h11;
    settle();
    total++;
    if ({if_valid, if_addr, if_instr} !== {1'b1, 32'h100, 32'h11})
      $display("FAIL rw_fetch: got %h want %h", {if_valid, if_addr, if_instr},
               {1'b1, 32'h100, 32'h11});
    else passed++;
    step();
    instr_rvalid = 1'b0;
  endtask

  task automatic test_redirect_hold();
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h22; id_stall = 1'b1;
    step();
    instr_rvalid = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h203;
    settle();
    total++;
    if ({ifid_flush, if_valid} !== 2'b10)
      $display("FAIL rh_flush: got %b want 10", {ifid_flush, if_valid});
    else passed++;
    step();
    redirect = 1'b0; id_stall = 1'b0;
    settle();
    total++;
    if ({instr_req, instr_addr, if_valid, ifid_flush} !== {1'b1, 32'h200, 1'b0, 1'b0})
      $display("FAIL rh_req: got %h want %h", {instr_req, instr_addr, if_valid, ifid_flush},
               {1'b1, 32'h200, 1'b0, 1'b0});
    else passed++;
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h33;
    settle();
    total++;
    if ({if_valid, if_addr, if_instr} !== {1'b1, 32'h200, 32'h33})
      $display("FAIL rh_fetch: got %h want %h", {if_valid, if_addr, if_instr},
               {1'b1, 32'h200, 32'h33});
    else passed++;
    step();
    instr_rvalid = 1'b0;
  endtask

  task automatic test_gnt_withheld_wrap();
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    settle();
    total++;
    if (ifid_flush !== 1'b1) $display("FAIL wrap_flush: got %b want 1", ifid_flush);
    else passed++;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      total++;
      if ({instr_req, instr_addr} !== {1'b1, 32'hFFFF_FFFC})
        $display("FAIL gnt_hold%0d: got %h want %h", k, {instr_req, instr_addr},
                 {1'b1, 32'hFFFF_FFFC});
      else passed++;
      step();
    end
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h44;
    settle();
    total++;
    if ({if_valid, if_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_fetch: got %h want %h", {if_valid, if_addr}, {1'b1, 32'hFFFF_FFFC});
    else passed++;
    step();
    instr_rvalid = 1'b0;
    settle();
    total++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_req: got %h want %h", {instr_req, instr_addr}, {1'b1, 32'h0});
    else passed++;
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_addr = 32'h300;
    step();
    redirect_addr = 32'h400;
    settle();
    total++;
    if ({ifid_flush, instr_req, instr_addr} !== {1'b1, 1'b1, 32'h300})
      $display("FAIL b2b_second: got %h want %h", {ifid_flush, instr_req, instr_addr},
               {1'b1, 1'b1, 32'h300});
    else passed++;
    step();
    redirect = 1'b0;
    settle();
    total++;
    if ({ifid_flush, instr_req, instr_addr} !== {1'b0, 1'b1, 32'h400})
      $display("FAIL b2b_last: got %h want %h", {ifid_flush, instr_req, instr_addr},
               {1'b0, 1'b1, 32'h400});
    else passed++;
  endtask

  task automatic test_reset_mid();
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; rst = 1'b1;
    settle();
    total++;
    if ({instr_req, instr_addr, if_valid} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL rst_mid: got %h want %h", {instr_req, instr_addr, if_valid},
               {1'b0, 32'h0, 1'b0});
    else passed++;
    step();
    rst = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h55;
    settle();
    total++;
    if ({instr_req, if_valid} !== 2'b00)
      $display("FAIL rst_late_rvalid: got %b want 00", {instr_req, if_valid});
    else passed++;
    step();
    instr_rvalid = 1'b0;
    settle();
    total++;
    if ({instr_req, instr_addr} !== {1'b1, 32'h0})
      $display("FAIL rst_restart: got %h want %h", {instr_req, instr_addr}, {1'b1, 32'h0});
    else passed++;
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall;
    logic [31:0] exp_redir;
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 32'd4;
    exp_redir = 32'd2;
`else
    exp_stall = 32'd0;
    exp_redir = 32'd0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    instr_gnt = 1'b1;
    step();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h66; id_stall = 1'b1;
    step();
    instr_rvalid = 1'b0;
    repeat (4) step();
    id_stall = 1'b0;
    step();
    settle();
    total++;
    if (perf_stall_cnt !== exp_stall)
      $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, exp_stall);
    else passed++;
    redirect = 1'b1; redirect_addr = 32'h500;
    step();
    step();
    redirect = 1'b0;
    settle();
    total++;
    if (perf_redir_cnt !== exp_redir)
      $display("FAIL perf_redir: got %0d want %0d", perf_redir_cnt, exp_redir);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_gnt_withheld_wrap();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
